// File: rtl/conv_pkg.sv
// conv_pkg: shared constants and types for the K=3 rate-1/2 convolutional code
// Contents: constraint length K, generator polynomials G0/G1, symbol width SYM_W,
// and the transmit FSM state type tx_state_t.
package conv_pkg;
  localparam int K = 3;
  localparam logic [K-1:0] G0 = 3'b111;
  localparam logic [K-1:0] G1 = 3'b101;
  localparam int SYM_W = 2;
  typedef enum logic [1:0] {IDLE, DATA, TAIL} tx_state_t;
endpackage

// File: rtl/conv_enc_core.sv
// conv_enc_core: combinational one-bit step of the K=3 rate-1/2 convolutional encoder
// Ports:
//   u        in   1      input bit
//   st       in   K-1    encoder state {u[n-1], u[n-2]}
//   sym      out  SYM_W  code symbol {c0, c1}
//   st_next  out  K-1    state after shifting u in
module conv_enc_core
  import conv_pkg::*;
(
  input  logic             u,
  input  logic [K-2:0]     st,
  output logic [SYM_W-1:0] sym,
  output logic [K-2:0]     st_next
);
  logic [K-1:0] w;
  assign w       = {u, st};
  assign sym     = {^(w & G0), ^(w & G1)};
  assign st_next = w[K-1:1];
endmodule

// File: rtl/conv_encoder_tx.sv
// conv_encoder_tx: rate-1/2 K=3 convolutional encoder, message in, registered code symbols out
// Optional feature macro: TAIL_FLUSH_EN (append K-1 zero tail bits per frame)
// Ports:
//   clk          in   1          rising-edge clock
//   reset_n      in   1          asynchronous active-low reset
//   msg          in   FRAME_LEN  message word, MSB encoded first
//   msg_valid    in   1          msg is valid
//   msg_ready    out  1          message accepted this cycle when valid
//   sym          out  DATA_W     code symbol {c0,c1}
//   sym_valid    out  1          sym is valid
//   sym_ready    in   1          downstream accepts sym
//   sym_first    out  1          first symbol of the frame
//   sym_last     out  1          last symbol of the frame
//   start_state  out  2          encoder state captured at frame start
module conv_encoder_tx
  import conv_pkg::*;
#(
  parameter int FRAME_LEN = 3,
  parameter int DATA_W    = SYM_W
)
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [FRAME_LEN-1:0] msg,
  input  logic                 msg_valid,
  output logic                 msg_ready,
  output logic [DATA_W-1:0]    sym,
  output logic                 sym_valid,
  input  logic                 sym_ready,
  output logic                 sym_first,
  output logic                 sym_last,
  output logic [1:0]           start_state
);
`ifdef TAIL_FLUSH_EN
  localparam int NTAIL = K - 1;
`else
  localparam int NTAIL = 0;
`endif
  localparam int NSYM = FRAME_LEN + NTAIL;
  localparam int CW = $clog2(FRAME_LEN + 2) + 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(NSYM - 1);
  localparam logic [CW-1:0] DATA_LEN = CW'(FRAME_LEN);
  tx_state_t            state;
  logic [FRAME_LEN-1:0] sr;
  logic [CW-1:0]        cnt;
  logic [K-2:0]         st;
  logic [K-2:0]         st_n;
  logic [SYM_W-1:0]     sym_n;
  logic                 accept;
  logic                 adv;
  logic                 done;
  logic                 tail_bit;
  logic                 u;
  logic [CW-1:0]        nidx;
  // cnt is the index of the symbol currently held in the output register
  assign accept   = (state == IDLE) && msg_valid && msg_ready;
  assign adv      = (state != IDLE) && sym_valid && sym_ready;
  assign done     = adv && (cnt == LAST_IDX);
  assign nidx     = cnt + 1'b1;
  assign tail_bit = nidx >= DATA_LEN;
  assign u        = accept ? msg[FRAME_LEN-1] : (tail_bit ? 1'b0 : sr[FRAME_LEN-1]);
  conv_enc_core u_core (
    .u       (u),
    .st      (st),
    .sym     (sym_n),
    .st_next (st_n)
  );
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      sr          <= '0;
      cnt         <= '0;
      st          <= '0;
      msg_ready   <= 1'b0;
      sym         <= '0;
      sym_valid   <= 1'b0;
      sym_first   <= 1'b0;
      sym_last    <= 1'b0;
      start_state <= '0;
    end else begin
      msg_ready <= ((state == IDLE) && !accept) || done;
      if (accept) begin
        sr          <= msg << 1;
        start_state <= st;
        st          <= st_n;
        cnt         <= '0;
        sym         <= DATA_W'(sym_n);
        sym_valid   <= 1'b1;
        sym_first   <= 1'b1;
        sym_last    <= (NSYM == 1);
        state       <= DATA;
      end else if (done) begin
        sym_valid <= 1'b0;
        sym_first <= 1'b0;
        sym_last  <= 1'b0;
        state     <= IDLE;
      end else if (adv) begin
        sr        <= sr << 1;
        st        <= st_n;
        cnt       <= nidx;
        sym       <= DATA_W'(sym_n);
        sym_first <= 1'b0;
        sym_last  <= (nidx == LAST_IDX);
        state     <= tail_bit ? TAIL : DATA;
      end
    end
  end
endmodule

// File: tb/tb_conv_encoder_tx.sv
// tb_conv_encoder_tx: self-checking bench for conv_encoder_tx (table vectors, corner sequences, random frames)
module tb_conv_encoder_tx;
  localparam int FL = 3;
`ifdef TAIL_FLUSH_EN
  localparam int NSYM = FL + 2;
`else
  localparam int NSYM = FL;
`endif
  typedef logic [1:0] sa_t [0:4];
  typedef struct {
    logic [2:0] msg;
    logic [1:0] ss;
    sa_t        s;
  } vec_t;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [2:0] msg = '0;
  logic       msg_valid = 1'b0;
  logic       msg_ready;
  logic [1:0] sym;
  logic       sym_valid;
  logic       sym_ready = 1'b0;
  logic       sym_first;
  logic       sym_last;
  logic [1:0] start_state;
  int checks = 0;
  int errors = 0;
  int hist = 0;
  vec_t tbl [0:2];
  conv_encoder_tx #(.FRAME_LEN(FL), .DATA_W(2)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .msg         (msg),
    .msg_valid   (msg_valid),
    .msg_ready   (msg_ready),
    .sym         (sym),
    .sym_valid   (sym_valid),
    .sym_ready   (sym_ready),
    .sym_first   (sym_first),
    .sym_last    (sym_last),
    .start_state (start_state)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // reference: the code bits are parities over the last three message bits ever sent since reset
  function automatic void model(input logic [2:0] m, output sa_t e, output logic [1:0] ss);
    int b;
    ss = {hist[0], hist[1]};
    for (int i = 0; i < 5; i++) e[i] = 2'b00;
    for (int i = 0; i < NSYM; i++) begin
      b = (i < FL) ? int'(m[FL-1-i]) : 0;
      hist = ((hist << 1) | b) & 7;
      e[i] = {1'(hist[0] + hist[1] + hist[2]), 1'(hist[0] + hist[2])};
    end
  endfunction
  task automatic do_frame(input logic [2:0] m, input sa_t e, input logic [1:0] ss, input int mode, input int abort_at);
    int n;
    int idx;
    int stall;
    logic r;
    idx = 0;
    stall = 0;
    n = 0;
    while (!msg_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("msg_ready_wait", msg_ready, 1);
    if (!msg_ready) return;
    msg = m;
    msg_valid = 1'b1;
    @(negedge clk);
    msg_valid = 1'b0;
    chk("ready_low_in_frame", msg_ready, 0);
    n = 0;
    while (idx < NSYM && n < 200) begin
      if (idx == abort_at) begin
        reset_n = 1'b0;
        #1;
        chk("rst_sym_valid", sym_valid, 0);
        chk("rst_msg_ready", msg_ready, 0);
        chk("rst_start_state", start_state, 0);
        @(negedge clk);
        reset_n = 1'b1;
        return;
      end
      chk("sym_valid", sym_valid, 1);
      chk("sym", sym, e[idx]);
      chk("sym_first", sym_first, idx == 0);
      chk("sym_last", sym_last, idx == NSYM - 1);
      chk("start_state", start_state, ss);
      r = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom % 2) : !(idx == 2 && stall < 3);
      if (!r) stall++;
      sym_ready = r;
      if (r) idx++;
      @(negedge clk);
      n++;
    end
    chk("frame_symbol_count", idx, NSYM);
    chk("end_sym_valid", sym_valid, 0);
    chk("end_msg_ready", msg_ready, 1);
    sym_ready = 1'b0;
  endtask
  task automatic back_to_back();
    sa_t e1, e2;
    logic [1:0] ss1, ss2;
    int acc;
    int k;
    logic prev_acc;
    model(3'b101, e1, ss1);
    model(3'b101, e2, ss2);
    acc = 0;
    k = 0;
    prev_acc = 1'b0;
    msg = 3'b101;
    msg_valid = 1'b1;
    sym_ready = 1'b1;
    for (int c = 0; c < 2 * (NSYM + 1); c++) begin
      if (prev_acc) begin
        chk("b2b_latency_valid", sym_valid, 1);
        chk("b2b_latency_first", sym_first, 1);
        chk("b2b_start_state", start_state, (acc == 1) ? ss1 : ss2);
      end
      if (sym_valid) begin
        chk("b2b_sym", sym, (k < NSYM) ? e1[k] : e2[k-NSYM]);
        k++;
      end
      prev_acc = msg_ready;
      if (msg_ready) acc++;
      @(negedge clk);
    end
    msg_valid = 1'b0;
    sym_ready = 1'b0;
    chk("b2b_accepts", acc, 2);
    chk("b2b_symbols", k, 2 * NSYM);
    chk("b2b_ready_again", msg_ready, 1);
  endtask
  initial begin
    sa_t e;
    logic [1:0] ss;
    logic [2:0] m;
`ifdef TAIL_FLUSH_EN
    tbl[0].msg = 3'b101; tbl[0].ss = 2'b00; tbl[0].s = '{2'b11, 2'b10, 2'b00, 2'b10, 2'b11};
    tbl[1].msg = 3'b111; tbl[1].ss = 2'b00; tbl[1].s = '{2'b11, 2'b01, 2'b10, 2'b01, 2'b11};
    tbl[2].msg = 3'b000; tbl[2].ss = 2'b00; tbl[2].s = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
`else
    tbl[0].msg = 3'b101; tbl[0].ss = 2'b00; tbl[0].s = '{2'b11, 2'b10, 2'b00, 2'b00, 2'b00};
    tbl[1].msg = 3'b111; tbl[1].ss = 2'b10; tbl[1].s = '{2'b01, 2'b10, 2'b10, 2'b00, 2'b00};
    tbl[2].msg = 3'b000; tbl[2].ss = 2'b11; tbl[2].s = '{2'b01, 2'b11, 2'b00, 2'b00, 2'b00};
`endif
    repeat (2) @(negedge clk);
    chk("reset_msg_ready", msg_ready, 0);
    chk("reset_sym_valid", sym_valid, 0);
    chk("reset_sym", sym, 0);
    chk("reset_first", sym_first, 0);
    chk("reset_last", sym_last, 0);
    chk("reset_start_state", start_state, 0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("idle_msg_ready", msg_ready, 1);
    for (int i = 0; i < 3; i++) begin
      model(tbl[i].msg, e, ss);
      do_frame(tbl[i].msg, tbl[i].s, tbl[i].ss, 0, -1);
    end
    model(3'b101, e, ss);
    do_frame(3'b101, e, ss, 2, -1);
    back_to_back();
    model(3'b101, e, ss);
    do_frame(3'b101, e, ss, 0, NSYM - 2);
    hist = 0;
    do_frame(tbl[0].msg, tbl[0].s, tbl[0].ss, 0, -1);
    hist = 0;
    model(tbl[0].msg, e, ss);
    for (int i = 0; i < 20; i++) begin
      m = 3'($urandom);
      model(m, e, ss);
      do_frame(m, e, ss, 1, -1);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
